// File: rtl/dadda_div_8_if.sv
// Start/done handshake bundle between a controller and the 16-by-8 restoring divider.
// The controller drives the operands; the divider returns the registered results.
interface dadda_div_8_if #(
   parameter int N = 8,
   parameter int M = 8
);
   logic             start;
   logic [N+M-1:0]   y;
   logic [M-1:0]     B;
   logic             busy;
   logic             done;
   logic [N+M-1:0]   Q;
   logic [M-1:0]     R;
   logic             div_zero;

   modport master (
      output start, y, B,
      input  busy, done, Q, R, div_zero
   );

   modport slave (
      input  start, y, B,
      output busy, done, Q, R, div_zero
   );
endinterface

// File: rtl/dadda_div_8.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// It inverts the 8x8 Dadda multiplier: y = A*B divided by B returns Q = A, R = 0.
module dadda_div_8 #(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   dadda_div_8_if.slave   bus
);
   localparam int W = N + M;
   localparam logic [4:0] LAST_STEP = 5'(W - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   d_q, d_d;
   logic [M-1:0]   bd_q, bd_d;
   logic [M:0]     p_q, p_d;
   logic [W-1:0]   qs_q, qs_d;
   logic [4:0]     cnt_q, cnt_d;
   logic [W-1:0]   q_q, q_d;
   logic [M-1:0]   r_q, r_d;
   logic           div_zero_q, div_zero_d;
   logic           done_q, done_d;

   logic [M:0]     trial;
   logic           fits;
   logic [M:0]     p_step;
   logic [W-1:0]   qs_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         d_q        <= '0;
         bd_q       <= '0;
         p_q        <= '0;
         qs_q       <= '0;
         cnt_q      <= '0;
         q_q        <= '0;
         r_q        <= '0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         d_q        <= d_d;
         bd_q       <= bd_d;
         p_q        <= p_d;
         qs_q       <= qs_d;
         cnt_q      <= cnt_d;
         q_q        <= q_d;
         r_q        <= r_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
      end
   end

   // The partial remainder stays below 2*Bd, so one extra bit holds the trial value.
   always_comb begin
      state_d    = state_q;
      d_d        = d_q;
      bd_d       = bd_q;
      p_d        = p_q;
      qs_d       = qs_q;
      cnt_d      = cnt_q;
      q_d        = q_q;
      r_d        = r_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;

      trial   = {p_q[M-1:0], d_q[W-1]};
      fits    = (trial >= {1'b0, bd_q});
      p_step  = fits ? (trial - {1'b0, bd_q}) : trial;
      qs_step = {qs_q[W-2:0], fits};

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.B != '0) begin
                  d_d     = bus.y;
                  bd_d    = bus.B;
                  p_d     = '0;
                  qs_d    = '0;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  q_d        = '1;
                  r_d        = '0;
                  div_zero_d = 1'b1;
                  done_d     = 1'b1;
               end
            end
         end
         RUN: begin
            d_d   = {d_q[W-2:0], 1'b0};
            p_d   = p_step;
            qs_d  = qs_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_STEP) begin
               q_d        = qs_step;
               r_d        = p_step[M-1:0];
               div_zero_d = 1'b0;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.done     = done_q;
   assign bus.Q        = q_q;
   assign bus.R        = r_q;
   assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_dadda_div_8.sv
// Directed bench for dadda_div_8: hand-computed quotients, divide-by-zero, handshake timing,
// mid-run start and reset, and a multiply/divide round trip over fixed operand pairs.
module tb_dadda_div_8;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int checks = 0;
   int errors = 0;

   dadda_div_8_if #(.N(8), .M(8)) bus ();

   dadda_div_8 #(.N(8), .M(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d *ERROR*", tag, got, exp);
      end
   endtask

   // Drives start for the accepting edge; returns at the negedge just after it.
   task automatic applyStimulus(input logic [15:0] yv, input logic [7:0] bv, input bit keepStart);
      @(negedge clk);
      bus.start = 1'b1;
      bus.y     = yv;
      bus.B     = bv;
      @(negedge clk);
      if (!keepStart) begin
         bus.start = 1'b0;
         bus.y     = 16'h0;
         bus.B     = 8'h0;
      end
   endtask

   task automatic waitDone(input bit keepStart, input int injectAt, output int lat, output int busyCnt);
      lat     = 0;
      busyCnt = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) busyCnt++;
         if (!keepStart) begin
            bus.start = (lat == injectAt);
            if (lat == injectAt) begin
               bus.y = 16'd500;
               bus.B = 8'd3;
            end
         end
         @(negedge clk);
         lat++;
      end
      if (!keepStart) bus.start = 1'b0;
      checkOutput("busy_at_done", {31'b0, bus.busy}, 32'd0);
   endtask

   task automatic checkResult(input string tag, input int lat, input int busyCnt,
                              input logic [15:0] eQ, input logic [7:0] eR, input logic eDz);
      int expLat;
      expLat = eDz ? 0 : 16;
      checkOutput({tag, "_latency"}, lat, expLat);
      checkOutput({tag, "_busy_cycles"}, busyCnt, expLat);
      checkOutput({tag, "_Q"}, {16'b0, bus.Q}, {16'b0, eQ});
      checkOutput({tag, "_R"}, {24'b0, bus.R}, {24'b0, eR});
      checkOutput({tag, "_div_zero"}, {31'b0, bus.div_zero}, {31'b0, eDz});
   endtask

   task automatic runOp(input string tag, input logic [15:0] yv, input logic [7:0] bv,
                        input logic [15:0] eQ, input logic [7:0] eR, input logic eDz);
      int lat, busyCnt;
      applyStimulus(yv, bv, 1'b0);
      waitDone(1'b0, -1, lat, busyCnt);
      checkResult(tag, lat, busyCnt, eQ, eR, eDz);
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
      checkOutput({tag, "_Q_held"}, {16'b0, bus.Q}, {16'b0, eQ});
   endtask

   logic [7:0] rtA [15] = '{8'd0, 8'd1, 8'd255, 8'd200, 8'd17, 8'd128, 8'd99, 8'd3,
                            8'd250, 8'd77, 8'd13, 8'd64, 8'd181, 8'd42, 8'd222};
   logic [7:0] rtB [15] = '{8'd1, 8'd255, 8'd255, 8'd3, 8'd19, 8'd2, 8'd101, 8'd250,
                            8'd7, 8'd77, 8'd13, 8'd64, 8'd9, 8'd200, 8'd111};

   initial begin
      int lat, busyCnt, doneSeen;
      logic [15:0] prod;

      bus.start = 1'b0;
      bus.y     = 16'h0;
      bus.B     = 8'h0;

      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
      checkOutput("reset_Q", {16'b0, bus.Q}, 32'd0);
      checkOutput("reset_R", {24'b0, bus.R}, 32'd0);
      checkOutput("reset_div_zero", {31'b0, bus.div_zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      runOp("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
      runOp("d65025_255", 16'd65025, 8'd255, 16'd255, 8'd0, 1'b0);
      runOp("dffff_1", 16'hFFFF, 8'd1, 16'd65535, 8'd0, 1'b0);
      runOp("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
      runOp("d5_0", 16'd5, 8'd0, 16'hFFFF, 8'd0, 1'b1);
      runOp("d10_3", 16'd10, 8'd3, 16'd3, 8'd1, 1'b0);

      for (int i = 0; i < 15; i++) begin
         prod = 16'(rtA[i]) * 16'(rtB[i]);
         runOp($sformatf("rt%0d", i), prod, rtB[i], 16'(rtA[i]), 8'd0, 1'b0);
      end

      // start pulsed during RUN must be ignored and not queued
      applyStimulus(16'd1000, 8'd7, 1'b0);
      waitDone(1'b0, 5, lat, busyCnt);
      checkResult("ignore_start", lat, busyCnt, 16'd142, 8'd6, 1'b0);
      @(negedge clk);
      checkOutput("ignore_start_no_queue", {31'b0, bus.busy}, 32'd0);

      // start held high through done accepts the next operation immediately
      applyStimulus(16'd1000, 8'd7, 1'b1);
      bus.y = 16'd65025;
      bus.B = 8'd255;
      waitDone(1'b1, -1, lat, busyCnt);
      checkResult("hold_first", lat, busyCnt, 16'd142, 8'd6, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.y     = 16'h0;
      bus.B     = 8'h0;
      waitDone(1'b0, -1, lat, busyCnt);
      checkResult("hold_second", lat, busyCnt, 16'd255, 8'd0, 1'b0);

      // asynchronous reset in the middle of a run
      applyStimulus(16'd1000, 8'd7, 1'b0);
      repeat (8) @(negedge clk);
      checkOutput("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("async_done", {31'b0, bus.done}, 32'd0);
      checkOutput("async_Q", {16'b0, bus.Q}, 32'd0);
      checkOutput("async_R", {24'b0, bus.R}, 32'd0);
      checkOutput("async_div_zero", {31'b0, bus.div_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done || bus.busy) doneSeen++;
      end
      checkOutput("reset_discards_op", doneSeen, 32'd0);
      runOp("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
